// File: rtl/key_press_gen_pkg.sv
// key_press_gen_pkg: state encoding and default parameter constants for the key press emulator
package key_press_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        DONE
    } state_t;

    localparam int N_DEF          = 1;
    localparam int BOUNCE_CNT_DEF = 4;
    localparam int BOUNCE_LEN_DEF = 2;
    localparam int HOLD_LEN_DEF   = 16;
    localparam int CW_DEF         = 8;

endpackage

// File: rtl/key_gen_timer.sv
// key_gen_timer: CW-bit segment timer with clear, enable and terminal-count flag
module key_gen_timer
#(
    parameter int CW = 8
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] tc,
    output logic [CW-1:0] cnt,
    output logic          hit
);

    // Count cycles within the current state; cleared on every state change
    always_ff @(posedge clk) begin
        if (!rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    assign hit = cnt == tc;

endmodule

// File: rtl/key_press_gen.sv
// key_press_gen: emulates a bouncing key press on one of N raw key lines; bounce phases enabled by KEY_PRESS_GEN_BOUNCE_EN
module key_press_gen
    import key_press_gen_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int BOUNCE_CNT = BOUNCE_CNT_DEF,
    parameter int BOUNCE_LEN = BOUNCE_LEN_DEF,
    parameter int HOLD_LEN   = HOLD_LEN_DEF,
    parameter int CW         = CW_DEF,
    localparam int KW        = (N > 1) ? $clog2(N) : 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [KW-1:0] key_sel,
    output logic [N-1:0]  key_out,
    output logic          busy,
    output logic          done,
    output logic          req_drop
);

    localparam logic [CW-1:0] BT = CW'(2 * BOUNCE_CNT * BOUNCE_LEN - 1);
    localparam logic [CW-1:0] HT = CW'(HOLD_LEN - 1);

    state_t        state, state_nxt;
    logic [KW-1:0] sel, sel_nxt;
    logic [CW-1:0] cnt, cnt_nxt, tc, seg;
    logic [N-1:0]  key_nxt;
    logic          hit, accept, clr, en, lvl;

    key_gen_timer #(.CW(CW)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .tc  (tc),
        .cnt (cnt),
        .hit (hit)
    );

    // Next state and terminal count for the phase being timed
    always_comb begin
        state_nxt = state;
        tc        = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = req && (32'(key_sel) < N);
`ifdef KEY_PRESS_GEN_BOUNCE_EN
                if (accept) state_nxt = BOUNCE_IN;
`else
                if (accept) state_nxt = HOLD;
`endif
            end
            BOUNCE_IN: begin
                tc = BT;
                if (hit) state_nxt = HOLD;
            end
            HOLD: begin
                tc = HT;
`ifdef KEY_PRESS_GEN_BOUNCE_EN
                if (hit) state_nxt = BOUNCE_OUT;
`else
                if (hit) state_nxt = DONE;
`endif
            end
            BOUNCE_OUT: begin
                tc = BT;
                if (hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Key level for the coming cycle, from next state and the timer value it will hold
    always_comb begin
        sel_nxt = accept ? key_sel : sel;
        clr     = state_nxt != state;
        en      = state != IDLE;
        cnt_nxt = clr ? '0 : (en ? cnt + CW'(1) : cnt);
        seg     = cnt_nxt / CW'(BOUNCE_LEN);
        lvl     = (state_nxt == HOLD) ||
                  (state_nxt == BOUNCE_IN && !seg[0]) ||
                  (state_nxt == BOUNCE_OUT && seg[0]);
        key_nxt = '0;
        key_nxt[sel_nxt] = lvl;
    end

    // State, latched key index, registered key lines and drop pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sel      <= '0;
            key_out  <= '0;
            req_drop <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            key_out  <= key_nxt;
            req_drop <= req && !accept;
        end
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

endmodule
